// File: rtl/foo_sched.sv
// foo_sched: round-robin scheduler sharing one fixed-latency foo datapath
// among N_REQ requesters; tags each issue and returns results via a FIFO.
// Ports: clk, rst (async active-low); req_vld/req_rdy/req_a..d per
// requester (packed i*WIDTH); dp_a..d/dp_arg_vld to datapath, dp_res/
// dp_res_vld back; rsp_vld/rsp_rdy/rsp_data/rsp_id result stream;
// busy (work outstanding); err (sticky result/tag disagreement).
module foo_sched #(
  parameter int WIDTH      = 32,
  parameter int N_REQ      = 4,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int IDW       = $clog2(N_REQ),
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  output logic [N_REQ-1:0]       req_rdy,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*WIDTH-1:0] req_c,
  input  logic [N_REQ*WIDTH-1:0] req_d,
  output logic [WIDTH-1:0]       dp_a,
  output logic [WIDTH-1:0]       dp_b,
  output logic [WIDTH-1:0]       dp_c,
  output logic [WIDTH-1:0]       dp_d,
  output logic                   dp_arg_vld,
  input  logic [WIDTH-1:0]       dp_res,
  input  logic                   dp_res_vld,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy,
  output logic                   err
);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_found;
  logic             can_issue;
  logic             xfer;
  logic [CW-1:0]    in_flight;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credit_used;
  logic [WIDTH-1:0] sel_a, sel_b, sel_c, sel_d;
  logic [LAT:0]     tag_vld;
  logic [IDW-1:0]   tag_id [LAT+1];
  logic             ret;
  logic             push;
  logic             pop;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [IDW-1:0]   mem_id [FIFO_DEPTH];

  // Every accepted op owns a FIFO slot until popped.
  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign can_issue   = credit_used < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!gnt_found && req_vld[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  assign xfer = gnt_found && can_issue;

  always_comb begin
    req_rdy = '0;
    if (xfer) req_rdy[gnt_id] = 1'b1;
  end

  assign sel_a = req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_b = req_b[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_c = req_c[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_d = req_d[int'(gnt_id)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gnt_id == IDW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_arg_vld <= 1'b0;
      dp_a       <= '0;
      dp_b       <= '0;
      dp_c       <= '0;
      dp_d       <= '0;
    end else begin
      dp_arg_vld <= xfer;
      if (xfer) begin
        dp_a <= sel_a;
        dp_b <= sel_b;
        dp_c <= sel_c;
        dp_d <= sel_d;
      end
    end
  end

  // Stage 0 loads alongside the issue register, so stage LAT lines
  // up with the datapath's result strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int k = 0; k <= LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld   <= {tag_vld[LAT-1:0], xfer};
      tag_id[0] <= gnt_id;
      for (int k = 1; k <= LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  // Guarded so a stray result strobe cannot wrap the counter.
  assign ret  = dp_res_vld && (in_flight != '0);
  assign push = dp_res_vld && tag_vld[LAT];
  assign pop  = rsp_vld && rsp_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight <= '0;
    end else begin
      unique case ({xfer, ret})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (dp_res_vld != tag_vld[LAT]) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_data[k] <= '0;
        mem_id[k]   <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= dp_res;
        mem_id[wr_ptr]   <= tag_id[LAT];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head comes straight from storage flops; nothing combinational
  // from the inputs reaches the response outputs.
  assign rsp_vld  = fifo_count != '0;
  assign rsp_data = mem_data[rd_ptr];
  assign rsp_id   = mem_id[rd_ptr];

  assign busy = (in_flight != '0) || rsp_vld || dp_arg_vld;

endmodule

// File: tb/tb_foo_sched.sv
// tb_foo_sched: directed bench for foo_sched with a behavioural
// scoreboard and a LAT-cycle datapath model.
module tb_foo_sched;
  localparam int W     = 32;
  localparam int N     = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld;
  logic [N-1:0]   req_rdy;
  logic [N*W-1:0] req_a, req_b, req_c, req_d;
  logic [W-1:0]   dp_a, dp_b, dp_c, dp_d, dp_res;
  logic           dp_arg_vld, dp_res_vld;
  logic           rsp_vld, rsp_rdy;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           busy, err;
  logic           inj;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  foo_sched #(.WIDTH(W), .N_REQ(N), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
    .dp_arg_vld(dp_arg_vld), .dp_res(dp_res), .dp_res_vld(dp_res_vld),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .err(err)
  );

  function automatic logic [W-1:0] fn(input logic [W-1:0] a, b, c, d);
    logic signed [W-1:0] x, r;
    x = (a - b) * (32'd3 * c + 32'd1) - (d << 2);
    r = x >>> 1;
    if (r < 0) r = r + 1;
    return r;
  endfunction

  // Datapath model: synchronous active-high-style clear while rst is low.
  logic [LAT-1:0] pv;
  logic [W-1:0]   pd [LAT];
  always @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], dp_arg_vld};
      pd[0] <= fn(dp_a, dp_b, dp_c, dp_d);
      for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
    end
  end
  assign dp_res_vld = pv[LAT-1] | inj;
  assign dp_res     = pd[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct { logic [W-1:0] d; int id; int due; } exp_t;
  typedef struct { logic [W-1:0] d; int id; int cyc; } log_t;

  exp_t m_q[$];
  log_t acc_log[$], got_log[$], arg_log[$];
  int   m_ptr = 0;
  int   m_out = 0;
  bit   m_err = 0;
  bit   m_iss = 0;
  logic [W-1:0] m_ia, m_ib, m_ic, m_id;

  // Scoreboard: outstanding = accepted - popped bounds credit; each
  // result becomes visible LAT+2 cycles after its accept, in order.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    logic ev;
    exp_t e;
    log_t l;
    cyc++;
    if (!rst) begin
      m_q.delete();
      m_ptr = 0; m_out = 0; m_err = 0; m_iss = 0;
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_dp_vld", dp_arg_vld, 0);
      chk("rst_dp_a", dp_a, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_rsp", {rsp_data, 30'd0, rsp_id}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
    end else begin
      g = -1;
      if (m_out < DEPTH)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_rdy", req_rdy, er);
      chk("dp_arg_vld", dp_arg_vld, m_iss);
      if (m_iss) begin
        chk("dp_ab", {dp_a, dp_b}, {m_ia, m_ib});
        chk("dp_cd", {dp_c, dp_d}, {m_ic, m_id});
      end
      ev = (m_q.size() > 0) && (m_q[0].due <= cyc);
      chk("rsp_vld", rsp_vld, ev);
      if (ev) begin
        chk("rsp_data", rsp_data, m_q[0].d);
        chk("rsp_id", rsp_id, m_q[0].id);
      end
      chk("busy", busy, m_out != 0);
      chk("err", err, m_err);

      for (int k = 0; k < N; k++)
        if (req_vld[k] && req_rdy[k]) begin
          l.id = k; l.cyc = cyc; l.d = '0; acc_log.push_back(l);
        end
      if (rsp_vld && rsp_rdy) begin
        l.id = rsp_id; l.cyc = cyc; l.d = rsp_data; got_log.push_back(l);
      end
      if (dp_arg_vld) begin
        l.id = 0; l.cyc = cyc; l.d = '0; arg_log.push_back(l);
      end

      m_iss = (g >= 0);
      if (g >= 0) begin
        m_ia = req_a[g*W +: W]; m_ib = req_b[g*W +: W];
        m_ic = req_c[g*W +: W]; m_id = req_d[g*W +: W];
        e.d = fn(m_ia, m_ib, m_ic, m_id); e.id = g; e.due = cyc + LAT + 2;
        m_q.push_back(e);
        m_out++;
        m_ptr = (g + 1) % N;
      end
      if (ev && rsp_rdy) begin
        void'(m_q.pop_front());
        m_out--;
      end
      if (inj) m_err = 1;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, b, c, d);
    req_a[i*W +: W] = a; req_b[i*W +: W] = b;
    req_c[i*W +: W] = c; req_d[i*W +: W] = d;
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, b, c, d);
    int t;
    t = 0;
    set_ops(i, a, b, c, d);
    req_vld[i] = 1'b1;
    #1;
    while (!req_rdy[i] && t < 50) begin step(); t++; end
    chk("issue_accept", req_rdy[i], 1'b1);
    step();
    req_vld[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, g0, r0, k;
    bit acc;
    rst = 1'b1; req_vld = '0; rsp_rdy = 1'b1; inj = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    #2 rst = 1'b0;
    step(3);
    rst = 1'b1;
    step(2);

    // single op, requester 1
    a0 = acc_log.size(); g0 = got_log.size(); r0 = arg_log.size();
    issue(1, 10, 4, 2, 1);
    step(LAT + 4);
    chk("t1_nacc", acc_log.size() - a0, 1);
    chk("t1_ngot", got_log.size() - g0, 1);
    if (got_log.size() > g0 && acc_log.size() > a0 && arg_log.size() > r0) begin
      chk("t1_data", got_log[g0].d, 19);
      chk("t1_id", got_log[g0].id, 1);
      chk("t1_rsp_lat", got_log[g0].cyc - acc_log[a0].cyc, LAT + 2);
      chk("t1_arg_lat", arg_log[r0].cyc - acc_log[a0].cyc, 1);
    end
    chk("t1_busy_idle", busy, 0);

    // negative rounding, requester 3 (leaves pointer at 0)
    g0 = got_log.size();
    issue(3, 0, 5, 1, 0);
    step(LAT + 4);
    chk("t2_ngot", got_log.size() - g0, 1);
    if (got_log.size() > g0) begin
      chk("t2_data", got_log[g0].d, 32'hFFFF_FFF7);
      chk("t2_id", got_log[g0].id, 3);
    end

    // round robin, all requesters for 8 cycles
    a0 = acc_log.size(); g0 = got_log.size();
    for (int i = 0; i < N; i++) set_ops(i, 3*i + 7, i, i + 1, 2);
    req_vld = '1;
    step(8);
    req_vld = '0;
    step(LAT + 6);
    chk("t3_nacc", acc_log.size() - a0, 8);
    chk("t3_ngot", got_log.size() - g0, 8);
    if (acc_log.size() - a0 >= 8 && got_log.size() - g0 >= 8) begin
      for (int j = 0; j < 8; j++) begin
        chk("t3_gnt_order", acc_log[a0 + j].id, j % N);
        chk("t3_rsp_order", got_log[g0 + j].id, j % N);
      end
      chk("t3_rsp_span", got_log[g0 + 7].cyc - got_log[g0].cyc, 7);
    end

    // backpressure: requester 0 streams with rsp_rdy low
    rsp_rdy = 1'b0;
    a0 = acc_log.size(); g0 = got_log.size();
    k = 0;
    for (int i = 0; i < 20; i++) begin
      set_ops(0, 2*k + 2, 0, 0, 0);
      req_vld[0] = 1'b1;
      #1 acc = req_rdy[0];
      step();
      if (acc) k++;
    end
    chk("t4_accepts", k, DEPTH);
    chk("t4_log_accepts", acc_log.size() - a0, DEPTH);
    chk("t4_stalled", req_rdy[0], 0);
    rsp_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_ops(0, 2*k + 2, 0, 0, 0);
      req_vld[0] = 1'b1;
      #1 acc = req_rdy[0];
      step();
      if (acc) k++;
    end
    req_vld = '0;
    chk("t4_resumed", k > DEPTH, 1);
    step(20);
    chk("t4_ngot", got_log.size() - g0, k);
    if (got_log.size() - g0 >= k)
      for (int j = 0; j < k; j++) begin
        chk("t4_data_order", got_log[g0 + j].d, j + 1);
        chk("t4_id", got_log[g0 + j].id, 0);
      end

    // spurious result strobe
    step(2);
    inj = 1'b1;
    step();
    inj = 1'b0;
    step(2);
    chk("t5_err", err, 1);
    chk("t5_fifo_empty", rsp_vld, 0);
    step(5);
    chk("t5_err_sticky", err, 1);

    // async reset with work in flight and queued
    rsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) issue(0, i + 1, 0, 0, 0);
    step(2);
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_rsp_vld", rsp_vld, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_rsp_vld", rsp_vld, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_req_rdy", req_rdy, 0);
    chk("t6_rst_dp", {dp_arg_vld, dp_a}, 0);
    chk("t6_rst_rsp", {rsp_data, rsp_id}, 0);
    step(2);
    rst = 1'b1;
    rsp_rdy = 1'b1;
    g0 = got_log.size();
    set_ops(0, 7, 2, 3, 2);
    for (int i = 1; i < N; i++) set_ops(i, 1, 1, 1, 1);
    req_vld = '1;
    #1 chk("t6_first_gnt", req_rdy, 4'b0001);
    step();
    req_vld = '0;
    step(LAT + 6);
    chk("t6_ngot", got_log.size() - g0, 1);
    if (got_log.size() > g0) begin
      chk("t6_data", got_log[g0].d, 21);
      chk("t6_id", got_log[g0].id, 0);
    end
    chk("t6_err_clear", err, 0);
    chk("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/foo_sched.md
Name: foo_sched

Overview:
Round-robin scheduler that shares one foo pipeline (fixed latency LAT, result = ((a-b)*(3c+1) - 4d) >>> 1, negative results +1) between N_REQ requesters.
- Accepts operand sets over per-requester valid/ready and issues at most one per cycle to the datapath.
- Tags each issue with its requester ID and returns each result with that ID through a backpressured output FIFO.
- Credit accounting guarantees a returning result always has a FIFO slot.

Parameters:
WIDTH, 32, operand/result width (matches datapath width).
N_REQ, 4, number of requesters (2..16).
LAT, 4, datapath latency in cycles, from dp_arg_vld to dp_res_vld.
FIFO_DEPTH, 8, result FIFO entries (power of two, >= LAT).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  asynchronous active-low reset.
req_vld  in  N_REQ  per-requester operand valid.
req_rdy  out  N_REQ  per-requester accept; one-hot or zero.
req_a  in  N_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]; same packing for b/c/d.
req_b  in  N_REQ*WIDTH  operand b.
req_c  in  N_REQ*WIDTH  operand c.
req_d  in  N_REQ*WIDTH  operand d.
dp_a  out  WIDTH  operand a to datapath; dp_b, dp_c, dp_d likewise.
dp_arg_vld  out  1  issue strobe to datapath.
dp_res  in  WIDTH  datapath result.
dp_res_vld  in  1  datapath result valid.
rsp_vld  out  1  result FIFO head valid.
rsp_rdy  in  1  consumer accepts head.
rsp_data  out  WIDTH  result.
rsp_id  out  $clog2(N_REQ)  originating requester.
busy  out  1  any op in flight or FIFO non-empty.
err  out  1  sticky: dp_res_vld disagreed with tag pipeline.

Behaviour:
- Reset (rst=0, async): req_rdy=0, dp_arg_vld=0, dp_a..d=0, rsp_vld=0, rsp_data=0, rsp_id=0, busy=0, err=0, RR pointer=0, tag pipe cleared, FIFO empty, in_flight=0.
- Credit: can_issue = (in_flight + fifo_count) < FIFO_DEPTH, using registered counts.
- Arbitration (combinational grant, registered pointer):
  - Search starts at ptr, wraps modulo N_REQ; the first i with req_vld[i]=1 is granted when can_issue=1.
  - req_rdy[i]=1 only for the granted i; all zero when can_issue=0.
  - Transfer occurs when req_vld[i] && req_rdy[i].
  - On transfer, ptr <= grant+1 (mod N_REQ); otherwise ptr holds.
- Issue register: on transfer, the next cycle has dp_arg_vld=1 and dp_a..d = the granted operands. Otherwise dp_arg_vld=0 and data holds.
- Tag pipe:
  - LAT+1 stages of {vld, id}, shifted every cycle.
  - Stage 0 loads {dp_arg_vld, issued id}.
  - The expected result slot is the stage aligned with dp_res_vld, i.e. LAT cycles after dp_arg_vld.
- in_flight: +1 on transfer, -1 when dp_res_vld is sampled; both in the same cycle = no change. Maximum FIFO_DEPTH.
- Result capture: when dp_res_vld=1, push {dp_res, tag id} into the FIFO. Overflow is impossible by credit.
- Mismatch: dp_res_vld != expected tag vld sets err=1 (sticky until reset). On spurious dp_res_vld with no tag, the push is dropped.
- FIFO:
  - Registered head; rsp_vld = !empty.
  - Pop on rsp_vld && rsp_rdy.
  - Push and pop in the same cycle leaves fifo_count unchanged.
  - First-word latency is 1 cycle after push.
  - Pointers wrap modulo FIFO_DEPTH.
- Throughput: one issue per cycle sustained while rsp_rdy=1.
- With rsp_rdy=0, at most FIFO_DEPTH ops are outstanding, then req_rdy=0 until pops occur.
- busy = (in_flight != 0) || !empty || dp_arg_vld.
- Reset mid-operation clears all tags, counts and FIFO. The system must reset the datapath (sync active-high rst) in the same window; results arriving after reset release without a tag set err.

Test Plan:
- Single op: requester 1, a=10 b=4 c=2 d=1 -> dp_arg_vld 1 cycle after accept; rsp_vld with rsp_data=19, rsp_id=1, LAT+2 cycles after accept; busy drops afterwards.
- Negative rounding: a=0 b=5 c=1 d=0 -> rsp_data=-9 (pre-round -10).
- Round robin: all 4 req_vld held high 8 cycles, rsp_rdy=1 -> grant order 0,1,2,3,0,1,2,3; rsp_id returns the same order, one per cycle.
- Backpressure: rsp_rdy=0, requester 0 streams -> exactly 8 accepts, then req_rdy=0. Raise rsp_rdy -> 8 results in order with no loss, and issues resume as credits return.
- Mismatch: inject a dp_res_vld pulse with no issue -> err=1 and stays 1; FIFO unchanged.
- Async reset with 3 ops in flight and FIFO holding 2 -> all outputs at reset values immediately. After release, a new op completes with correct result and id 0 first in RR.
